// File: rtl/cpld_pkg.sv
// rtl/cpld_pkg.sv - shared state encoding, owner codes and default constants for the flash arbiter
package cpld_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_GRANT_DSP = 3'd1,
      ST_GRANT_CPU = 3'd2,
      ST_LOCKOUT   = 3'd3,
      ST_GUARD     = 3'd4
   } state_t;

   localparam logic [1:0] OWNER_NONE = 2'b00;
   localparam logic [1:0] OWNER_DSP  = 2'b01;
   localparam logic [1:0] OWNER_CPU  = 2'b10;
   localparam logic [1:0] OWNER_LOCK = 2'b11;

   localparam int unsigned DEF_GUARD_CYCLES   = 4;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 65535;

   function automatic logic [1:0] owner_of(input state_t s);
      case (s)
         ST_GRANT_DSP: owner_of = OWNER_DSP;
         ST_GRANT_CPU: owner_of = OWNER_CPU;
         ST_LOCKOUT:   owner_of = OWNER_LOCK;
         default:      owner_of = OWNER_NONE;
      endcase
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for an active-low chip select, resets to inactive (1)
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/spi_flash_arbiter.sv
// rtl/spi_flash_arbiter.sv - arbitrates one serial flash between a DSP and a CPU SPI master
module spi_flash_arbiter
   import cpld_pkg::*;
#(
   parameter int unsigned GUARD_CYCLES   = DEF_GUARD_CYCLES,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic       sysclk,
   input  logic       reset,
   input  logic       dsp_cs_INV,
   input  logic       dsp_clk,
   input  logic       dsp_mosi,
   input  logic       cpu_cs_INV,
   input  logic       cpu_clk,
   input  logic       cpu_mosi,
   input  logic       flash_miso,
   output logic       flash_clk,
   output logic       flash_mosi,
   output logic       flash_cs_INV,
   output logic       dsp_miso,
   output logic       cpu_miso,
   output logic [1:0] owner,
   output logic       timeout_flag
);

   logic dsp_cs_s, cpu_cs_s;
   logic dsp_req, cpu_req;

   sync_2ff u_sync_dsp (.clk(sysclk), .reset(reset), .d(dsp_cs_INV), .q(dsp_cs_s));
   sync_2ff u_sync_cpu (.clk(sysclk), .reset(reset), .d(cpu_cs_INV), .q(cpu_cs_s));

   assign dsp_req = ~dsp_cs_s;
   assign cpu_req = ~cpu_cs_s;

   state_t      state_q, state_d;
   logic [15:0] grant_cnt_q, grant_cnt_d;
   logic [15:0] guard_cnt_q, guard_cnt_d;
   logic        last_cpu_q, last_cpu_d;
   logic        timeout_flag_q, timeout_flag_d;
   logic        grant_expired, guard_done, locked_released;

   always_comb begin
      state_d        = state_q;
      grant_cnt_d    = (grant_cnt_q == 16'hFFFF) ? grant_cnt_q : grant_cnt_q + 16'd1;
      guard_cnt_d    = guard_cnt_q;
      last_cpu_d     = last_cpu_q;
      timeout_flag_d = timeout_flag_q;

      grant_expired   = (32'(grant_cnt_q) + 32'd1) >= TIMEOUT_CYCLES;
      guard_done      = (32'(guard_cnt_q) + 32'd1) >= GUARD_CYCLES;
      locked_released = last_cpu_q ? ~cpu_req : ~dsp_req;

      case (state_q)
         ST_IDLE: begin
            grant_cnt_d = '0;
            guard_cnt_d = '0;
            // On a tie, the requester that did not own the bus last wins.
            if (dsp_req && (!cpu_req || last_cpu_q)) begin
               state_d    = ST_GRANT_DSP;
               last_cpu_d = 1'b0;
            end else if (cpu_req) begin
               state_d    = ST_GRANT_CPU;
               last_cpu_d = 1'b1;
            end
         end
         ST_GRANT_DSP, ST_GRANT_CPU: begin
            if ((state_q == ST_GRANT_DSP) ? ~dsp_req : ~cpu_req) begin
               state_d     = ST_GUARD;
               guard_cnt_d = '0;
            end else if (grant_expired) begin
               state_d        = ST_LOCKOUT;
               timeout_flag_d = 1'b1;
            end
         end
         ST_LOCKOUT: begin
            if (locked_released) begin
               state_d     = ST_GUARD;
               guard_cnt_d = '0;
            end
         end
         ST_GUARD: begin
            guard_cnt_d = guard_cnt_q + 16'd1;
            if (guard_done) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         grant_cnt_q    <= '0;
         guard_cnt_q    <= '0;
         last_cpu_q     <= 1'b1;
         timeout_flag_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         grant_cnt_q    <= grant_cnt_d;
         guard_cnt_q    <= guard_cnt_d;
         last_cpu_q     <= last_cpu_d;
         timeout_flag_q <= timeout_flag_d;
      end
   end

   // Data path is purely combinational from the registered state: SCK/MOSI/MISO never see a sysclk flop.
   always_comb begin
      flash_clk    = 1'b0;
      flash_mosi   = 1'b0;
      flash_cs_INV = 1'b1;
      dsp_miso     = 1'b0;
      cpu_miso     = 1'b0;
      case (state_q)
         ST_GRANT_DSP: begin
            flash_clk    = dsp_clk;
            flash_mosi   = dsp_mosi;
            flash_cs_INV = dsp_cs_INV;
            dsp_miso     = flash_miso;
         end
         ST_GRANT_CPU: begin
            flash_clk    = cpu_clk;
            flash_mosi   = cpu_mosi;
            flash_cs_INV = cpu_cs_INV;
            cpu_miso     = flash_miso;
         end
         default: ;
      endcase
   end

   assign owner        = owner_of(state_q);
   assign timeout_flag = timeout_flag_q;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// tb/tb_spi_flash_arbiter.sv - directed, table-driven bench for spi_flash_arbiter
module tb_spi_flash_arbiter;

   localparam int G = 4;
   localparam int T = 100;

   logic       sysclk = 1'b0;
   logic       reset;
   logic       dsp_cs_INV, dsp_clk, dsp_mosi;
   logic       cpu_cs_INV, cpu_clk, cpu_mosi;
   logic       flash_miso;
   logic       flash_clk, flash_mosi, flash_cs_INV;
   logic       dsp_miso, cpu_miso;
   logic [1:0] owner;
   logic       timeout_flag;
   logic [4:0] bus;

   int total = 0;
   int bad   = 0;

   spi_flash_arbiter #(.GUARD_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
      .sysclk      (sysclk),
      .reset       (reset),
      .dsp_cs_INV  (dsp_cs_INV),
      .dsp_clk     (dsp_clk),
      .dsp_mosi    (dsp_mosi),
      .cpu_cs_INV  (cpu_cs_INV),
      .cpu_clk     (cpu_clk),
      .cpu_mosi    (cpu_mosi),
      .flash_miso  (flash_miso),
      .flash_clk   (flash_clk),
      .flash_mosi  (flash_mosi),
      .flash_cs_INV(flash_cs_INV),
      .dsp_miso    (dsp_miso),
      .cpu_miso    (cpu_miso),
      .owner       (owner),
      .timeout_flag(timeout_flag)
   );

   always #5 sysclk = ~sysclk;

   assign bus = {flash_clk, flash_mosi, flash_cs_INV, dsp_miso, cpu_miso};

   // stim = {dsp_clk, dsp_mosi, cpu_clk, cpu_mosi, flash_miso}
   // exp  = {flash_clk, flash_mosi, flash_cs_INV, dsp_miso, cpu_miso}
   typedef struct {
      logic       phase;
      logic [4:0] stim;
      logic [4:0] exp;
   } vec_t;

   vec_t vecs [12];

   task automatic step();
      @(posedge sysclk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic wait_owner(input logic [1:0] val, input int budget, input string name, output int n);
      n = 0;
      while (owner !== val && n < budget) begin
         step();
         n++;
      end
      total++;
      if (owner !== val) begin
         bad++;
         $display("FAIL %s: owner %0h after %0d cycles, want %0h", name, owner, n, val);
      end
   endtask

   task automatic settle(input int cycles);
      for (int k = 0; k < cycles; k++) step();
   endtask

   task automatic run_table(input logic phase, input string name);
      for (int i = 0; i < 12; i++) begin
         if (vecs[i].phase == phase) begin
            {dsp_clk, dsp_mosi, cpu_clk, cpu_mosi, flash_miso} = vecs[i].stim;
            #1;
            check(name, 32'(bus), 32'(vecs[i].exp));
         end
      end
      {dsp_clk, dsp_mosi, cpu_clk, cpu_mosi, flash_miso} = 5'b00000;
   endtask

   initial begin
      int n;

      vecs[0]  = '{1'b0, 5'b10010, 5'b10000};
      vecs[1]  = '{1'b0, 5'b01101, 5'b01010};
      vecs[2]  = '{1'b0, 5'b11001, 5'b11010};
      vecs[3]  = '{1'b0, 5'b00111, 5'b00010};
      vecs[4]  = '{1'b0, 5'b11110, 5'b11000};
      vecs[5]  = '{1'b0, 5'b00000, 5'b00000};
      vecs[6]  = '{1'b1, 5'b10010, 5'b01000};
      vecs[7]  = '{1'b1, 5'b01101, 5'b10001};
      vecs[8]  = '{1'b1, 5'b11001, 5'b00001};
      vecs[9]  = '{1'b1, 5'b00111, 5'b11001};
      vecs[10] = '{1'b1, 5'b11110, 5'b11000};
      vecs[11] = '{1'b1, 5'b00101, 5'b10001};

      reset = 1'b1;
      {dsp_cs_INV, cpu_cs_INV} = 2'b11;
      {dsp_clk, dsp_mosi, cpu_clk, cpu_mosi, flash_miso} = 5'b00000;
      settle(3);
      check("reset_owner", 32'(owner), 32'h0);
      check("reset_bus", 32'(bus), 32'h04);
      check("reset_timeout_flag", 32'(timeout_flag), 32'h0);
      reset = 1'b0;
      settle(3);

      // Idle bus ignores requester lines.
      {dsp_clk, dsp_mosi, cpu_clk, cpu_mosi, flash_miso} = 5'b11111;
      #1;
      check("idle_bus", 32'(bus), 32'h04);
      {dsp_clk, dsp_mosi, cpu_clk, cpu_mosi, flash_miso} = 5'b00000;

      // DSP-only grant, SCK mirroring, pass-through table.
      step();
      dsp_cs_INV = 1'b0;
      wait_owner(2'b01, 6, "dsp_grant", n);
      check("dsp_latency", 32'(n), 32'd3);
      for (int i = 0; i < 16; i++) begin
         step();
         dsp_clk    = ~dsp_clk;
         flash_miso = i[0];
         #1;
         check("sck_mirror", 32'(flash_clk), 32'((i % 2) == 0));
         check("cpu_miso_zero", 32'(cpu_miso), 32'h0);
      end
      run_table(1'b0, "dsp_table");
      settle(15);
      step();
      dsp_cs_INV = 1'b1;
      wait_owner(2'b00, 6, "dsp_release", n);
      check("dsp_release_latency", 32'(n), 32'd3);
      settle(8);

      // CPU-only grant and pass-through table.
      step();
      cpu_cs_INV = 1'b0;
      wait_owner(2'b10, 6, "cpu_grant", n);
      run_table(1'b1, "cpu_table");
      step();
      cpu_cs_INV = 1'b1;
      wait_owner(2'b00, 6, "cpu_release", n);
      settle(8);

      // Tie after reset: DSP first, CPU after the guard gap.
      reset = 1'b1;
      settle(2);
      reset = 1'b0;
      settle(3);
      step();
      {dsp_cs_INV, cpu_cs_INV} = 2'b00;
      wait_owner(2'b01, 6, "tie_dsp_first", n);
      check("tie_latency", 32'(n), 32'd3);
      step();
      dsp_cs_INV = 1'b1;
      wait_owner(2'b00, 6, "tie_dsp_release", n);
      wait_owner(2'b10, 10, "tie_cpu_grant", n);
      check("tie_cpu_gap", 32'(n), 32'(G + 1));
      step();
      cpu_cs_INV = 1'b1;
      wait_owner(2'b00, 6, "tie_cpu_release", n);
      settle(8);

      // Contention: CPU asks while DSP owns the bus.
      step();
      dsp_cs_INV = 1'b0;
      wait_owner(2'b01, 6, "cont_dsp_grant", n);
      step();
      cpu_cs_INV = 1'b0;
      dsp_clk    = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         check("cont_bus", {28'h0, owner, flash_cs_INV, flash_clk}, 32'b0101);
      end
      step();
      dsp_clk    = 1'b0;
      dsp_cs_INV = 1'b1;
      wait_owner(2'b00, 6, "cont_dsp_release", n);
      wait_owner(2'b10, 10, "cont_cpu_grant", n);
      check("cont_cpu_gap", 32'(n), 32'(G + 1));
      step();
      cpu_cs_INV = 1'b1;
      wait_owner(2'b00, 6, "cont_cpu_release", n);
      settle(8);

      // Timeout: CPU holds past TIMEOUT_CYCLES, DSP waits through the lockout.
      step();
      cpu_cs_INV = 1'b0;
      wait_owner(2'b10, 6, "to_cpu_grant", n);
      settle(T - 1);
      check("to_pre_owner", 32'(owner), 32'h2);
      step();
      check("to_owner_lock", 32'(owner), 32'h3);
      check("to_flash_cs", 32'(flash_cs_INV), 32'h1);
      check("to_flag", 32'(timeout_flag), 32'h1);
      dsp_cs_INV = 1'b0;
      settle(80);
      check("to_lock_holds", 32'(owner), 32'h3);
      cpu_cs_INV = 1'b1;
      wait_owner(2'b00, 6, "to_lock_release", n);
      check("to_release_latency", 32'(n), 32'd3);
      wait_owner(2'b01, 10, "to_dsp_grant", n);
      check("to_dsp_gap", 32'(n), 32'(G + 1));
      check("to_flag_sticky", 32'(timeout_flag), 32'h1);
      step();
      dsp_cs_INV = 1'b1;
      wait_owner(2'b00, 6, "to_dsp_release", n);
      settle(8);

      // Reset at grant cycle 10.
      step();
      dsp_cs_INV = 1'b0;
      wait_owner(2'b01, 6, "rst_dsp_grant", n);
      settle(9);
      reset = 1'b1;
      step();
      check("rst_owner", 32'(owner), 32'h0);
      check("rst_flash_cs", 32'(flash_cs_INV), 32'h1);
      check("rst_flag", 32'(timeout_flag), 32'h0);
      reset = 1'b0;
      wait_owner(2'b01, 6, "rst_regrant", n);
      check("rst_regrant_latency", 32'(n), 32'd3);
      step();
      dsp_cs_INV = 1'b1;
      wait_owner(2'b00, 6, "rst_release", n);
      settle(8);

      // Same owner back-to-back: one-cycle release still pays the guard.
      step();
      dsp_cs_INV = 1'b0;
      wait_owner(2'b01, 6, "b2b_grant", n);
      settle(3);
      step();
      dsp_cs_INV = 1'b1;
      step();
      dsp_cs_INV = 1'b0;
      wait_owner(2'b00, 6, "b2b_release", n);
      wait_owner(2'b01, 10, "b2b_regrant", n);
      check("b2b_gap", 32'(n), 32'(G + 1));
      step();
      dsp_cs_INV = 1'b1;
      settle(8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
